// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a valid/ready result port.
// Logic ops, ADD/SUB, SLT and shifts take one cycle. MUL (shift-add) and DIVU/REMU
// (restoring division) iterate WIDTH times. The result is held until it is taken.
//
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   in_valid / in_ready      - request handshake (in_ready high only when idle)
//   A, B, alu_control        - operands and operation select, captured on acceptance
//   out_valid / out_ready    - result handshake (out_valid high only while holding a result)
//   resultado, zero          - registered result and registered A==B flag
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic             zero
);

    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   res_q;
    logic               zero_q;
    logic [3:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;

    // Iteration registers, shared by MUL and DIVU/REMU:
    //   MUL : acc_q = partial product, x_q = shifted multiplicand, y_q = shifted multiplier
    //   DIV : acc_q = partial remainder, x_q = dividend shifting out / quotient shifting in,
    //         y_q = divisor
    logic [WIDTH-1:0]   acc_q, x_q, y_q;
    logic [WIDTH-1:0]   acc_d, x_d, y_d;
    logic [WIDTH:0]     rem_sh;

    logic [WIDTH-1:0]   single_d;
    logic [WIDTH-1:0]   multi_res_d;
    logic [SH_W-1:0]    sh_amt;
    logic               is_multi;

    // Single-cycle result computed straight from the request operands
    always_comb begin
        single_d = '0;
        sh_amt   = B[SH_W-1:0];
        is_multi = 1'b0;
        case (alu_control)
            OP_AND:  single_d = A & B;
            OP_OR:   single_d = A | B;
            OP_ADD:  single_d = A + B;
            OP_XOR:  single_d = A ^ B;
            OP_SUB:  single_d = A - B;
            OP_SLT:  single_d = WIDTH'(A < B);
            OP_SLL:  single_d = A << sh_amt;
            OP_SRL:  single_d = A >> sh_amt;
            OP_MUL, OP_DIVU, OP_REMU: is_multi = 1'b1;
            default: single_d = '0;
        endcase
    end

    // One shift-add or restoring-division step
    always_comb begin
        acc_d       = acc_q;
        x_d         = x_q;
        y_d         = y_q;
        rem_sh      = {acc_q, x_q[WIDTH-1]};
        multi_res_d = '0;
        if (op_q == OP_MUL) begin
            if (y_q[0]) begin
                acc_d = acc_q + x_q;
            end
            x_d = x_q << 1;
            y_d = y_q >> 1;
        end else begin
            // Divisor of zero always "fits": quotient fills with ones, remainder ends as A
            if (rem_sh >= {1'b0, y_q}) begin
                acc_d = rem_sh[WIDTH-1:0] - y_q;
                x_d   = {x_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = rem_sh[WIDTH-1:0];
                x_d   = {x_q[WIDTH-2:0], 1'b0};
            end
        end
        if (op_q == OP_DIVU) begin
            multi_res_d = x_d;
        end else begin
            multi_res_d = acc_d;
        end
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            op_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= alu_control;
                        zero_q     <= (A == B);
                        in_ready_q <= 1'b0;
                        if (is_multi) begin
                            state_q <= S_BUSY;
                            acc_q   <= '0;
                            x_q     <= A;
                            y_q     <= B;
                            cnt_q   <= '0;
                        end else begin
                            state_q     <= S_DONE;
                            res_q       <= single_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    // The last iteration's result is written on the same edge that enters DONE
                    if (cnt_q == LAST_ITER) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= multi_res_d;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign resultado = res_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst32_n, rst8_n;
    logic [31:0] a_s, b_s;
    logic [3:0]  op_s;
    logic        iv32, iv8, out_ready;
    logic        ir32, ov32, z32, ir8, ov8, z8;
    logic [31:0] res32;
    logic [7:0]  res8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst32_n),
        .in_valid(iv32), .in_ready(ir32),
        .A(a_s), .B(b_s), .alu_control(op_s),
        .out_valid(ov32), .out_ready(out_ready),
        .resultado(res32), .zero(z32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n),
        .in_valid(iv8), .in_ready(ir8),
        .A(a_s[7:0]), .B(b_s[7:0]), .alu_control(op_s),
        .out_valid(ov8), .out_ready(out_ready),
        .resultado(res8), .zero(z8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_res(input bit w8);
        return w8 ? 64'(res8) : 64'(res32);
    endfunction
    function automatic logic get_ov(input bit w8);
        return w8 ? ov8 : ov32;
    endfunction
    function automatic logic get_ir(input bit w8);
        return w8 ? ir8 : ir32;
    endfunction
    function automatic logic get_z(input bit w8);
        return w8 ? z8 : z32;
    endfunction

    task automatic set_iv(input bit w8, input logic v);
        if (w8) iv8 = v;
        else    iv32 = v;
    endtask

    // Reference model: plain arithmetic on 64-bit values, masked to the width
    function automatic logic [63:0] model(input int unsigned w, input logic [3:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask;
        int unsigned sh;
        mask = (64'd1 << w) - 64'd1;
        sh   = 32'(b % 64'(w));
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return (a + b) & mask;
            4'd3:    return a ^ b;
            4'd6:    return (a - b) & mask;
            4'd7:    return (a < b) ? 64'd1 : 64'd0;
            4'd4:    return (a << sh) & mask;
            4'd5:    return a >> sh;
            4'd8:    return (a * b) & mask;
            4'd9:    return (b == 0) ? mask : a / b;
            4'd10:   return (b == 0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    // Issue one request, check latency/result/zero, optionally stall in DONE, then release
    task automatic do_op(input bit w8, input logic [63:0] a_in, input logic [63:0] b_in,
                         input logic [3:0] op, input int stall);
        int unsigned w;
        logic [63:0] mask, a, b, exp_r;
        int lat, exp_lat, guard;
        w       = w8 ? 8 : 32;
        mask    = (64'd1 << w) - 64'd1;
        a       = a_in & mask;
        b       = b_in & mask;
        exp_r   = model(w, op, a, b);
        exp_lat = (op == 4'd8 || op == 4'd9 || op == 4'd10) ? int'(w) + 1 : 1;
        a_s  = a[31:0];
        b_s  = b[31:0];
        op_s = op;
        set_iv(w8, 1'b1);
        guard = 0;
        while (!get_ir(w8) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_req", 64'(get_ir(w8)), 64'd1);
        @(posedge clk); #1;
        set_iv(w8, 1'b0);
        lat = 1;
        while (!get_ov(w8) && lat < 100) begin
            check("in_ready_while_busy", 64'(get_ir(w8)), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency op=%0d w=%0d", op, w), 64'(lat), 64'(exp_lat));
        check($sformatf("resultado op=%0d w=%0d a=%0h b=%0h", op, w, a, b), get_res(w8), exp_r);
        check("zero", 64'(get_z(w8)), 64'(a == b));
        check("in_ready_in_done", 64'(get_ir(w8)), 64'd0);
        // Hold the result with a competing request on the input that must be ignored
        for (int i = 0; i < stall; i++) begin
            a_s  = $urandom;
            b_s  = $urandom;
            op_s = 4'($urandom_range(0, 15));
            set_iv(w8, 1'b1);
            @(posedge clk); #1;
            check("stall_out_valid", 64'(get_ov(w8)), 64'd1);
            check("stall_in_ready", 64'(get_ir(w8)), 64'd0);
            check("stall_resultado", get_res(w8), exp_r);
            check("stall_zero", 64'(get_z(w8)), 64'(a == b));
        end
        set_iv(w8, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", 64'(get_ov(w8)), 64'd0);
        check("release_in_ready", 64'(get_ir(w8)), 64'd1);
    endtask

    task automatic rand_op(input bit w8);
        logic [63:0] a, b;
        logic [3:0]  op;
        int mode;
        op   = 4'($urandom_range(0, 15));
        a    = {32'd0, $urandom};
        b    = {32'd0, $urandom};
        mode = int'($urandom_range(0, 7));
        case (mode)
            0: b = a;
            1: b = 64'd0;
            2: begin a = 64'($urandom_range(0, 300)); b = 64'($urandom_range(0, 20)); end
            default: ;
        endcase
        do_op(w8, a, b, op, int'($urandom_range(0, 2)));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst32_n = 1'b0; rst8_n = 1'b0;
        iv32 = 1'b0; iv8 = 1'b0; out_ready = 1'b0;
        a_s = '0; b_s = '0; op_s = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready32", 64'(ir32), 64'd1);
        check("reset_out_valid32", 64'(ov32), 64'd0);
        check("reset_res32", 64'(res32), 64'd0);
        check("reset_zero32", 64'(z32), 64'd0);
        check("reset_in_ready8", 64'(ir8), 64'd1);
        check("reset_out_valid8", 64'(ov8), 64'd0);
        check("reset_res8", 64'(res8), 64'd0);
        check("reset_zero8", 64'(z8), 64'd0);
        rst32_n = 1'b1; rst8_n = 1'b1;

        // Directed WIDTH=32 cases
        do_op(1'b0, 64'hFFFF_FFFF, 64'd1, 4'b0010, 0);
        do_op(1'b0, 64'h1_0000, 64'h1_0001, 4'b1000, 0);
        do_op(1'b0, 64'd100, 64'd7, 4'b1001, 0);
        do_op(1'b0, 64'd100, 64'd7, 4'b1010, 0);
        do_op(1'b0, 64'd100, 64'd0, 4'b1001, 0);
        do_op(1'b0, 64'd100, 64'd0, 4'b1010, 0);
        do_op(1'b0, 64'h1234, 64'h5678, 4'b0010, 5);
        do_op(1'b0, 64'hDEAD, 64'hBEEF, 4'b1000, 5);
        do_op(1'b0, 64'h55, 64'h3, 4'b1011, 0);

        // Directed WIDTH=8 cases
        do_op(1'b1, 64'd3, 64'd200, 4'b0111, 0);
        do_op(1'b1, 64'h80, 64'h0F, 4'b0101, 0);
        do_op(1'b1, 64'd5, 64'd5, 4'b0110, 0);
        do_op(1'b1, 64'd200, 64'd13, 4'b1001, 0);
        do_op(1'b1, 64'd200, 64'd13, 4'b1010, 2);

        // Reset in the middle of a multiply
        a_s = 32'h1_0000; b_s = 32'h1_0001; op_s = 4'b1000;
        iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_busy_out_valid", 64'(ov32), 64'd0);
        check("pre_reset_busy_in_ready", 64'(ir32), 64'd0);
        rst32_n = 1'b0;
        #1;
        check("midbusy_reset_in_ready", 64'(ir32), 64'd1);
        check("midbusy_reset_out_valid", 64'(ov32), 64'd0);
        check("midbusy_reset_res", 64'(res32), 64'd0);
        check("midbusy_reset_zero", 64'(z32), 64'd0);
        #2;
        rst32_n = 1'b1;
        do_op(1'b0, 64'h1_0000, 64'h1_0001, 4'b1000, 0);

        for (int i = 0; i < 40; i++) rand_op(1'b0);
        for (int i = 0; i < 60; i++) rand_op(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
